j4_io_hub: RTL and testbench

//  Slot-aware IO responder directly downstream of the 4-slot barrel core.

---
 rtl/j4_io_pkg.sv | 49 ++++
 rtl/j4_mbox_fifo.sv | 57 +++++
 rtl/j4_io_hub.sv | 116 +++++++++++
 tb/tb_j4_io_hub.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/j4_io_pkg.sv
// Shared constants for the j4 IO hub: address map, slot width, status layout and
// the access-type decoder used by the top level.
package j4_io_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SLOT_W    = 2;
    localparam int unsigned TICK_W    = 16;

    localparam logic [15:0] ADDR_PUSH = 16'h1000;
    localparam logic [15:0] ADDR_POP  = 16'h1004;
    localparam logic [15:0] ADDR_STAT = 16'h1008;
    localparam logic [15:0] ADDR_KILL = 16'h100C;
    localparam logic [15:0] ADDR_SLOT = 16'h1010;
    localparam logic [15:0] ADDR_TICK = 16'h1014;

    localparam int unsigned ST_FULL_LSB     = 0;
    localparam int unsigned ST_NONEMPTY_BIT = 4;
    localparam int unsigned ST_OVF_BIT      = 5;

    typedef enum logic [2:0] {
        AccNone,
        AccPush,
        AccPop,
        AccStat,
        AccKill,
        AccSlot,
        AccTick
    } acc_e;

    // Push occupies four consecutive addresses, one per destination mailbox.
    function automatic acc_e acc_decode(input logic [15:0] addr);
        acc_e acc;
        acc = AccNone;
        if (addr[15:SLOT_W] == ADDR_PUSH[15:SLOT_W]) begin
            acc = AccPush;
        end else begin
            case (addr)
                ADDR_POP:  acc = AccPop;
                ADDR_STAT: acc = AccStat;
                ADDR_KILL: acc = AccKill;
                ADDR_SLOT: acc = AccSlot;
                ADDR_TICK: acc = AccTick;
                default:   acc = AccNone;
            endcase
        end
        return acc;
    endfunction

endpackage

// File: rtl/j4_mbox_fifo.sv
// Single inter-slot mailbox: circular buffer with head peek, push/pop and a
// synchronous flush that outranks both.
module j4_mbox_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/j4_io_hub.sv
// Slot-aware IO responder for the 4-slot barrel core: mailboxes, kill register and,
// when J4_IO_TICKS_EN is defined, a free-running 16-bit tick counter at 0x1014.
module j4_io_hub
    import j4_io_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [15:0]       io_addr,
    input  logic [WIDTH-1:0]  io_dout,
    input  logic [SLOT_W-1:0] io_slot,
    output logic [WIDTH-1:0]  io_din,
    output logic [3:0]        kill_slot_rq
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    acc_e                 w_acc;
    logic [SLOT_W-1:0]    w_tgt;
    logic [WIDTH-1:0]     w_head [NUM_SLOTS];
    logic [CW-1:0]        w_count [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_full;
    logic [NUM_SLOTS-1:0] w_empty;
    logic [NUM_SLOTS-1:0] w_push;
    logic [NUM_SLOTS-1:0] w_pop;
    logic [NUM_SLOTS-1:0] w_ovf_nxt;
    logic                 w_drop;
    logic [WIDTH-1:0]     w_status;
    logic [NUM_SLOTS-1:0] r_ovf;
    logic [NUM_SLOTS-1:0] r_kill;

    assign w_acc        = acc_decode(io_addr);
    assign w_tgt        = io_addr[SLOT_W-1:0];
    assign kill_slot_rq = r_kill;

    for (genvar n = 0; n < NUM_SLOTS; n++) begin : g_mbox
        assign w_push[n] = io_wr && (w_acc == AccPush) && (w_tgt == SLOT_W'(n));
        assign w_pop[n]  = io_rd && (w_acc == AccPop) && (io_slot == SLOT_W'(n));

        j4_mbox_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH)
        ) u_fifo (
            .i_clk   (clk),
            .i_rst   (reset),
            .i_push  (w_push[n]),
            .i_pop   (w_pop[n]),
            .i_flush (r_kill[n]),
            .i_data  (io_dout),
            .o_head  (w_head[n]),
            .o_full  (w_full[n]),
            .o_empty (w_empty[n]),
            .o_count (w_count[n])
        );
    end

    // A push into a mailbox being flushed is discarded silently, not counted as overflow.
    assign w_drop = io_wr && (w_acc == AccPush) && w_full[w_tgt] && !r_kill[w_tgt];

    always_comb begin
        w_ovf_nxt = r_ovf;
        if (w_drop) w_ovf_nxt[io_slot] = 1'b1;
        if (io_rd && (w_acc == AccStat)) w_ovf_nxt[io_slot] = 1'b0;
        w_ovf_nxt = w_ovf_nxt & ~r_kill;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf  <= '0;
            r_kill <= '0;
        end else begin
            r_ovf  <= w_ovf_nxt;
            r_kill <= (io_wr && (w_acc == AccKill) && (io_slot == '0)) ? io_dout[3:0] : '0;
        end
    end

`ifdef J4_IO_TICKS_EN
    logic [TICK_W-1:0] r_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick <= '0;
        end else if (io_wr && (w_acc == AccTick) && (io_slot == '0)) begin
            r_tick <= io_dout[TICK_W-1:0];
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end
`endif

    always_comb begin
        w_status                                = '0;
        w_status[ST_FULL_LSB +: NUM_SLOTS]      = w_full;
        w_status[ST_NONEMPTY_BIT]               = (w_count[io_slot] != '0);
        w_status[ST_OVF_BIT]                    = r_ovf[io_slot];
    end

    // Read data is decoded from address and slot alone; io_rd only gates side effects.
    always_comb begin
        io_din = '0;
        unique case (w_acc)
            AccPop:  if (!w_empty[io_slot]) io_din = w_head[io_slot];
            AccStat: io_din = w_status;
            AccSlot: io_din[SLOT_W-1:0] = io_slot;
`ifdef J4_IO_TICKS_EN
            AccTick: io_din = WIDTH'(r_tick);
`endif
            default: io_din = '0;
        endcase
    end

endmodule

// File: tb/tb_j4_io_hub.sv
// Self-checking bench for j4_io_hub: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based mailbox model.
module tb_j4_io_hub;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [1:0]  io_slot;
    logic [15:0] io_din;
    logic [3:0]  kill_slot_rq;

    always #5 clk = ~clk;

    j4_io_hub #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io_rd        (io_rd),
        .io_wr        (io_wr),
        .io_addr      (io_addr),
        .io_dout      (io_dout),
        .io_slot      (io_slot),
        .io_din       (io_din),
        .kill_slot_rq (kill_slot_rq)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one queue per mailbox plus sticky overflow flags.
    logic [15:0] mq [4][$];
    logic        m_ovf [4];
    logic [3:0]  m_kill;
`ifdef J4_IO_TICKS_EN
    logic [15:0] m_tick;
`endif

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] dout;
        logic [1:0]  slot;
        logic        chk;
        logic [15:0] exp_din;
        logic [3:0]  exp_kill;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string name, input logic rd, input logic wr,
                                input logic [15:0] addr, input logic [15:0] dout,
                                input logic [1:0] slot, input logic chk,
                                input logic [15:0] exp_din, input logic [3:0] exp_kill);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.dout = dout;
        v.slot = slot; v.chk = chk; v.exp_din = exp_din; v.exp_kill = exp_kill;
        return v;
    endfunction

    task automatic model_clear();
        for (int n = 0; n < 4; n++) begin
            mq[n].delete();
            m_ovf[n] = 1'b0;
        end
        m_kill = 4'b0;
`ifdef J4_IO_TICKS_EN
        m_tick = 16'h0;
`endif
    endtask

    function automatic logic [15:0] model_din(input logic [15:0] a, input logic [1:0] s);
        logic [15:0] r;
        r = 16'h0;
        if (a == 16'h1004) begin
            if (mq[s].size() != 0) r = mq[s][0];
        end else if (a == 16'h1008) begin
            for (int n = 0; n < 4; n++) r[n] = (mq[n].size() == DEPTH);
            r[4] = (mq[s].size() != 0);
            r[5] = m_ovf[s];
        end else if (a == 16'h1010) begin
            r = {14'b0, s};
        end
`ifdef J4_IO_TICKS_EN
        else if (a == 16'h1014) begin
            r = m_tick;
        end
`endif
        return r;
    endfunction

    // Advance the model across one clock edge for the access presented this cycle.
    task automatic model_step(input logic rd, input logic wr, input logic [15:0] a,
                              input logic [15:0] d, input logic [1:0] s);
        logic [3:0] nk;
        int         t;
        nk = 4'b0;
        if (wr && a >= 16'h1000 && a <= 16'h1003) begin
            t = int'(a[1:0]);
            if (!m_kill[t]) begin
                if (mq[t].size() == DEPTH) m_ovf[s] = 1'b1;
                else mq[t].push_back(d);
            end
        end
        if (rd && a == 16'h1004 && mq[s].size() != 0) void'(mq[s].pop_front());
        if (rd && a == 16'h1008) m_ovf[s] = 1'b0;
        if (wr && a == 16'h100C && s == 2'd0) nk = d[3:0];
        for (int n = 0; n < 4; n++) begin
            if (m_kill[n]) begin
                mq[n].delete();
                m_ovf[n] = 1'b0;
            end
        end
`ifdef J4_IO_TICKS_EN
        if (wr && a == 16'h1014 && s == 2'd0) m_tick = d;
        else m_tick = m_tick + 16'h1;
`endif
        m_kill = nk;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input string name, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] dout,
                         input logic [1:0] slot, input logic chk,
                         input logic [15:0] exp_din, input logic [3:0] exp_kill);
        @(negedge clk);
        io_rd = rd; io_wr = wr; io_addr = addr; io_dout = dout; io_slot = slot;
        #1;
        if (chk) check(name, io_din, exp_din);
        check({name, "_kill"}, {12'b0, kill_slot_rq}, {12'b0, exp_kill});
        model_step(rd, wr, addr, dout, slot);
    endtask

    task automatic mcycle(input string name, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] dout,
                          input logic [1:0] slot);
        cycle(name, rd, wr, addr, dout, slot, rd, model_din(addr, slot), m_kill);
    endtask

    task automatic idle(input string name, input logic [3:0] exp_kill);
        cycle(name, 1'b0, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 16'h0, exp_kill);
    endtask

    initial begin
        reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0;
        io_addr = 16'h0; io_dout = 16'h0; io_slot = 2'd0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_kill", {12'b0, kill_slot_rq}, 16'h0);
        reset = 1'b0;

        tbl.push_back(mk("rst_stat0",  1, 0, 16'h1008, 16'h0,    2'd0, 1, 16'h0000, 4'h0));
        tbl.push_back(mk("rst_pop3",   1, 0, 16'h1004, 16'h0,    2'd3, 1, 16'h0000, 4'h0));
        tbl.push_back(mk("slot_id2",   1, 0, 16'h1010, 16'h0,    2'd2, 1, 16'h0002, 4'h0));
        tbl.push_back(mk("unmapped",   1, 0, 16'h2000, 16'h0,    2'd1, 1, 16'h0000, 4'h0));
`ifndef J4_IO_TICKS_EN
        tbl.push_back(mk("tick_off",   1, 0, 16'h1014, 16'h0,    2'd0, 1, 16'h0000, 4'h0));
`endif
        tbl.push_back(mk("t1_push",    0, 1, 16'h1002, 16'hBEEF, 2'd1, 0, 16'h0000, 4'h0));
        tbl.push_back(mk("t1_pop",     1, 0, 16'h1004, 16'h0,    2'd2, 1, 16'hBEEF, 4'h0));
        tbl.push_back(mk("t1_empty",   1, 0, 16'h1004, 16'h0,    2'd2, 1, 16'h0000, 4'h0));
        tbl.push_back(mk("t2_push1",   0, 1, 16'h1003, 16'hA001, 2'd0, 0, 16'h0000, 4'h0));
        tbl.push_back(mk("t2_push2",   0, 1, 16'h1003, 16'hA002, 2'd0, 0, 16'h0000, 4'h0));
        tbl.push_back(mk("t2_push3",   0, 1, 16'h1003, 16'hA003, 2'd0, 0, 16'h0000, 4'h0));
        tbl.push_back(mk("t2_push4",   0, 1, 16'h1003, 16'hA004, 2'd0, 0, 16'h0000, 4'h0));
        tbl.push_back(mk("t2_push5",   0, 1, 16'h1003, 16'h5555, 2'd0, 0, 16'h0000, 4'h0));
        tbl.push_back(mk("t2_stat",    1, 0, 16'h1008, 16'h0,    2'd0, 1, 16'h0028, 4'h0));
        tbl.push_back(mk("t2_stat2",   1, 0, 16'h1008, 16'h0,    2'd0, 1, 16'h0008, 4'h0));
        tbl.push_back(mk("t2_pop3",    1, 0, 16'h1004, 16'h0,    2'd3, 1, 16'hA001, 4'h0));
        tbl.push_back(mk("t2_stat3",   1, 0, 16'h1008, 16'h0,    2'd3, 1, 16'h0010, 4'h0));
        tbl.push_back(mk("t3_fill1",   0, 1, 16'h1001, 16'h0011, 2'd0, 0, 16'h0000, 4'h0));
        tbl.push_back(mk("t3_fill2",   0, 1, 16'h1002, 16'h0022, 2'd0, 0, 16'h0000, 4'h0));
        tbl.push_back(mk("t3_kill_s2", 0, 1, 16'h100C, 16'h000F, 2'd2, 0, 16'h0000, 4'h0));
        tbl.push_back(mk("t3_kill_s0", 0, 1, 16'h100C, 16'h0006, 2'd0, 0, 16'h0000, 4'h0));
        tbl.push_back(mk("t3_kill_on", 0, 0, 16'h0000, 16'h0,    2'd0, 0, 16'h0000, 4'h6));
        tbl.push_back(mk("t3_kill_off",0, 0, 16'h0000, 16'h0,    2'd0, 0, 16'h0000, 4'h0));
        tbl.push_back(mk("t3_pop1",    1, 0, 16'h1004, 16'h0,    2'd1, 1, 16'h0000, 4'h0));
        tbl.push_back(mk("t3_pop2",    1, 0, 16'h1004, 16'h0,    2'd2, 1, 16'h0000, 4'h0));
        tbl.push_back(mk("t3_stat1",   1, 0, 16'h1008, 16'h0,    2'd1, 1, 16'h0000, 4'h0));

        foreach (tbl[i]) begin
            cycle(tbl[i].name, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].dout, tbl[i].slot,
                  tbl[i].chk, tbl[i].exp_din, tbl[i].exp_kill);
        end

        // Wrap: ten values through mailbox 0, then drain mailbox 3 (0x5555 must be gone).
        for (int i = 1; i <= 10; i++) begin
            cycle("t4_push", 0, 1, 16'h1000, 16'(i), 2'd3, 0, 16'h0, 4'h0);
            cycle("t4_pop", 1, 0, 16'h1004, 16'h0, 2'd0, 1, 16'(i), 4'h0);
        end
        cycle("t4_drain_a", 1, 0, 16'h1004, 16'h0, 2'd3, 1, 16'hA002, 4'h0);
        cycle("t4_drain_b", 1, 0, 16'h1004, 16'h0, 2'd3, 1, 16'hA003, 4'h0);
        cycle("t4_drain_c", 1, 0, 16'h1004, 16'h0, 2'd3, 1, 16'hA004, 4'h0);
        cycle("t4_drain_e", 1, 0, 16'h1004, 16'h0, 2'd3, 1, 16'h0000, 4'h0);

        // Reset mid-operation with mailbox 1 holding data and a kill pulse in flight.
        cycle("t5_fill_a", 0, 1, 16'h1001, 16'h0AAA, 2'd2, 0, 16'h0, 4'h0);
        cycle("t5_fill_b", 0, 1, 16'h1001, 16'h0BBB, 2'd2, 0, 16'h0, 4'h0);
        cycle("t5_kill", 0, 1, 16'h100C, 16'h0001, 2'd0, 0, 16'h0, 4'h0);
        @(negedge clk);
        io_rd = 1'b0; io_wr = 1'b0;
        #1 reset = 1'b1;
        #1 check("t5_kill_rst", {12'b0, kill_slot_rq}, 16'h0);
        #2 reset = 1'b0;
        model_clear();
        for (int s = 0; s < 4; s++) begin
            cycle("t5_stat", 1, 0, 16'h1008, 16'h0, 2'(s), 1, 16'h0000, 4'h0);
        end
        cycle("t5_pop1", 1, 0, 16'h1004, 16'h0, 2'd1, 1, 16'h0000, 4'h0);

`ifdef J4_IO_TICKS_EN
        cycle("t6_load", 0, 1, 16'h1014, 16'hFFFE, 2'd0, 0, 16'h0, 4'h0);
        idle("t6_wait", 4'h0);
        idle("t6_wait", 4'h0);
        idle("t6_wait", 4'h0);
        cycle("t6_tick", 1, 0, 16'h1014, 16'h0, 2'd0, 1, 16'h0001, 4'h0);
`else
        cycle("t6_load", 0, 1, 16'h1014, 16'hFFFE, 2'd0, 0, 16'h0, 4'h0);
        idle("t6_wait", 4'h0);
        cycle("t6_tick", 1, 0, 16'h1014, 16'h0, 2'd0, 1, 16'h0000, 4'h0);
`endif

        for (int i = 0; i < 800; i++) begin
            logic [1:0]  s;
            logic [15:0] d;
            int          op;
            s  = 2'($urandom_range(0, 3));
            d  = 16'($urandom);
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: mcycle("rnd_push", 0, 1, 16'h1000 | 16'($urandom_range(0, 3)), d, s);
                3, 4:    mcycle("rnd_pop", 1, 0, 16'h1004, d, s);
                5:       mcycle("rnd_stat", 1, 0, 16'h1008, d, s);
                6: begin
                    if ($urandom_range(0, 3) == 0) mcycle("rnd_kill", 0, 1, 16'h100C, d, s);
                    else mcycle("rnd_slot", 1, 0, 16'h1010, d, s);
                end
                7:       mcycle("rnd_rdaddr", 1, 0, 16'h1000 | 16'($urandom_range(0, 31)), d, s);
                8:       mcycle("rnd_wraddr", 0, 1, 16'($urandom), d, s);
                default: mcycle("rnd_idle", 0, 0, 16'h0, d, s);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
